// File: rtl/bus_arbiter_if.sv
// Single-beat leader/follower bus shared by the arbiter ports.
// Leader drives requests; follower returns read data.
interface bus;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        read_req;
  logic        write_req;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport leader (
    output addr,
    output write_data,
    output byte_enable,
    output read_req,
    output write_req,
    input  read_data,
    input  read_data_valid
  );

  modport follower (
    input  addr,
    input  write_data,
    input  byte_enable,
    input  read_req,
    input  write_req,
    output read_data,
    output read_data_valid
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-leader round-robin arbiter with one outstanding read,
// per-leader holding registers and a read timeout.
module bus_arbiter #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  bus.follower       leaders [0:1],
  bus.leader         follower,
  output logic [1:0] leader_busy,
  output logic       overflow_err,
  output logic       timeout_err
);
  typedef enum logic {IDLE, READ_WAIT} state_e;

  typedef struct packed {
    logic        valid;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } hold_t;

  localparam logic [15:0] TmoLim = 16'(TimeoutCycles);

  logic [1:0]  l_rd, l_wr, l_rv;
  logic [31:0] l_addr [2];
  logic [31:0] l_wd [2];
  logic [3:0]  l_be [2];
  logic [31:0] rdata;

  for (genvar g = 0; g < 2; g++) begin : g_ldr
    assign l_rd[g]   = leaders[g].read_req;
    assign l_wr[g]   = leaders[g].write_req;
    assign l_addr[g] = leaders[g].addr;
    assign l_wd[g]   = leaders[g].write_data;
    assign l_be[g]   = leaders[g].byte_enable;
    assign leaders[g].read_data       = rdata;
    assign leaders[g].read_data_valid = l_rv[g];
  end

  state_e      state_q;
  logic        owner_q;
  logic [15:0] cnt_q;
  logic        ptr_q;
  hold_t       hold_q [2];
  logic [1:0]  wr_iss_q;
  logic [31:0] f_addr_q, f_wd_q;
  logic [3:0]  f_be_q;
  logic        f_rd_q, f_wr_q;
  logic        ovf_q, tmo_q;

  logic rw, resp, tmo_hit, done, can_grant;

  assign rw   = (state_q == READ_WAIT);
  assign resp = rw & follower.read_data_valid;

  // A response in the limit cycle wins over the timeout.
  assign tmo_hit = rw & ~follower.read_data_valid
                 & (TmoLim != 16'd0) & (cnt_q == TmoLim);

  assign done      = resp | tmo_hit;
  assign can_grant = ~rw | done;
  assign rdata     = tmo_hit ? 32'hFFFF_FFFF : follower.read_data;
  assign l_rv[0]   = done & ~owner_q;
  assign l_rv[1]   = done & owner_q;

  // A write stays visible as busy during its issue cycle.
  assign leader_busy[0] = hold_q[0].valid | wr_iss_q[0]
                        | (rw & ~owner_q);
  assign leader_busy[1] = hold_q[1].valid | wr_iss_q[1]
                        | (rw & owner_q);

  logic [1:0] acc, pend;
  logic       ovf_ev, gidx;
  hold_t      cand [2];
  hold_t      hold_d [2];

  assign acc    = (l_rd | l_wr) & ~leader_busy;
  assign ovf_ev = (|(l_rd & l_wr)) | (|((l_rd | l_wr) & leader_busy));

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cand[i] = hold_q[i];
      if (!hold_q[i].valid) begin
        cand[i].valid = acc[i];
        cand[i].rd    = l_rd[i];
        cand[i].addr  = l_addr[i];
        cand[i].wdata = l_wd[i];
        cand[i].be    = l_be[i];
      end
      pend[i] = cand[i].valid & can_grant;
    end
  end

  always_comb begin
    gidx = 1'b0;
    unique case (pend)
      2'b01:   gidx = 1'b0;
      2'b10:   gidx = 1'b1;
      2'b11:   gidx = ptr_q;
      default: gidx = 1'b0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = cand[i];
      if (pend[i] && (gidx == i[0]))
        hold_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      hold_q   <= '{default: '0};
      wr_iss_q <= '0;
      f_addr_q <= '0;
      f_wd_q   <= '0;
      f_be_q   <= '0;
      f_rd_q   <= 1'b0;
      f_wr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      wr_iss_q <= '0;
      f_rd_q   <= 1'b0;
      f_wr_q   <= 1'b0;
      ovf_q    <= ovf_q | ovf_ev;
      tmo_q    <= tmo_q | tmo_hit;
      if (|pend) begin
        f_addr_q <= cand[gidx].addr;
        f_wd_q   <= cand[gidx].wdata;
        f_be_q   <= cand[gidx].be;
        f_rd_q   <= cand[gidx].rd;
        f_wr_q   <= ~cand[gidx].rd;
        // Pointer only moves when both leaders competed.
        if (&pend)
          ptr_q <= ~gidx;
        if (cand[gidx].rd) begin
          state_q <= READ_WAIT;
          owner_q <= gidx;
          cnt_q   <= '0;
        end else begin
          state_q        <= IDLE;
          wr_iss_q[gidx] <= 1'b1;
        end
      end else if (done) begin
        state_q <= IDLE;
      end else if (rw) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign follower.addr        = f_addr_q;
  assign follower.write_data  = f_wd_q;
  assign follower.byte_enable = f_be_q;
  assign follower.read_req    = f_rd_q;
  assign follower.write_req   = f_wr_q;
  assign overflow_err         = ovf_q;
  assign timeout_err          = tmo_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed per-cycle vector bench for bus_arbiter.
// Inputs change on negedge; outputs are checked 1 time unit later.
module tb_bus_arbiter;
  logic       clk;
  logic       reset_n;
  logic [1:0] busy;
  logic       ovf, tmo;

  bus ldr [0:1] ();
  bus fol ();

  bus_arbiter #(.TimeoutCycles(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .leaders      (ldr),
    .follower     (fol),
    .leader_busy  (busy),
    .overflow_err (ovf),
    .timeout_err  (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        frv;
    logic [31:0] frd;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    logic [1:0]  e_busy;
    logic [1:0]  e_lrv;
    logic [31:0] e_lrd;
    logic        e_ovf;
    logic        e_tmo;
  } vec_t;

  vec_t tv [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ldr[0].read_req    = v.rd[0];
    ldr[0].write_req   = v.wr[0];
    ldr[0].addr        = v.a0;
    ldr[0].write_data  = v.d0;
    ldr[0].byte_enable = 4'hF;
    ldr[1].read_req    = v.rd[1];
    ldr[1].write_req   = v.wr[1];
    ldr[1].addr        = v.a1;
    ldr[1].write_data  = v.d1;
    ldr[1].byte_enable = 4'h3;
    fol.read_data_valid = v.frv;
    fol.read_data       = v.frd;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic [1:0] lrv;
    lrv = {ldr[1].read_data_valid, ldr[0].read_data_valid};
    chk("rd_req", i, 32'(fol.read_req), 32'(v.e_rd));
    chk("wr_req", i, 32'(fol.write_req), 32'(v.e_wr));
    chk("busy", i, 32'(busy), 32'(v.e_busy));
    chk("lrv", i, 32'(lrv), 32'(v.e_lrv));
    chk("ovf", i, 32'(ovf), 32'(v.e_ovf));
    chk("tmo", i, 32'(tmo), 32'(v.e_tmo));
    if (v.e_rd || v.e_wr) begin
      chk("addr", i, fol.addr, v.e_addr);
      chk("be", i, 32'(fol.byte_enable), 32'(v.e_be));
    end
    if (v.e_wr)
      chk("wdata", i, fol.write_data, v.e_wd);
    if (v.e_lrv != 2'b00) begin
      chk("lrd0", i, ldr[0].read_data, v.e_lrd);
      chk("lrd1", i, ldr[1].read_data, v.e_lrd);
    end
  endtask

  task automatic build();
    // single write
    tv.push_back(vec_t'{default: '0, wr: 2'b01,
      a0: 32'h1000_0004, d0: 32'hA5A5_0001});
    tv.push_back(vec_t'{default: '0, e_wr: 1'b1,
      e_addr: 32'h1000_0004, e_wd: 32'hA5A5_0001,
      e_be: 4'hF, e_busy: 2'b01});
    tv.push_back(vec_t'{default: '0});
    // simultaneous writes, leader 0 favoured
    tv.push_back(vec_t'{default: '0, wr: 2'b11,
      a0: 32'h2000_0000, d0: 32'h1111_1111,
      a1: 32'h3000_0000, d1: 32'h2222_2222});
    tv.push_back(vec_t'{default: '0, e_wr: 1'b1,
      e_addr: 32'h2000_0000, e_wd: 32'h1111_1111,
      e_be: 4'hF, e_busy: 2'b11});
    tv.push_back(vec_t'{default: '0, e_wr: 1'b1,
      e_addr: 32'h3000_0000, e_wd: 32'h2222_2222,
      e_be: 4'h3, e_busy: 2'b10});
    tv.push_back(vec_t'{default: '0});
    // simultaneous writes again, leader 1 favoured
    tv.push_back(vec_t'{default: '0, wr: 2'b11,
      a0: 32'h2000_0010, d0: 32'h3333_3333,
      a1: 32'h3000_0010, d1: 32'h4444_4444});
    tv.push_back(vec_t'{default: '0, e_wr: 1'b1,
      e_addr: 32'h3000_0010, e_wd: 32'h4444_4444,
      e_be: 4'h3, e_busy: 2'b11});
    tv.push_back(vec_t'{default: '0, e_wr: 1'b1,
      e_addr: 32'h2000_0010, e_wd: 32'h3333_3333,
      e_be: 4'hF, e_busy: 2'b01});
    tv.push_back(vec_t'{default: '0});
    // leader 1 read, leader 0 write held meanwhile
    tv.push_back(vec_t'{default: '0, rd: 2'b10,
      a1: 32'h4000_0000});
    tv.push_back(vec_t'{default: '0, wr: 2'b01,
      a0: 32'h5000_0000, d0: 32'h5555_5555,
      e_rd: 1'b1, e_addr: 32'h4000_0000,
      e_be: 4'h3, e_busy: 2'b10});
    tv.push_back(vec_t'{default: '0, e_busy: 2'b11});
    tv.push_back(vec_t'{default: '0, e_busy: 2'b11});
    tv.push_back(vec_t'{default: '0, frv: 1'b1,
      frd: 32'h1234_5678, e_busy: 2'b11,
      e_lrv: 2'b10, e_lrd: 32'h1234_5678});
    tv.push_back(vec_t'{default: '0, e_wr: 1'b1,
      e_addr: 32'h5000_0000, e_wd: 32'h5555_5555,
      e_be: 4'hF, e_busy: 2'b01});
    tv.push_back(vec_t'{default: '0});
    // timeout after 4 wait cycles
    tv.push_back(vec_t'{default: '0, rd: 2'b01,
      a0: 32'h6000_0000});
    tv.push_back(vec_t'{default: '0, e_rd: 1'b1,
      e_addr: 32'h6000_0000, e_be: 4'hF, e_busy: 2'b01});
    for (int k = 0; k < 3; k++)
      tv.push_back(vec_t'{default: '0, e_busy: 2'b01});
    tv.push_back(vec_t'{default: '0, e_busy: 2'b01,
      e_lrv: 2'b01, e_lrd: 32'hFFFF_FFFF});
    tv.push_back(vec_t'{default: '0, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, frv: 1'b1,
      frd: 32'hDEAD_BEEF, e_tmo: 1'b1});
    // overflow: second write while busy
    tv.push_back(vec_t'{default: '0, wr: 2'b01,
      a0: 32'h7000_0000, d0: 32'h7777_7777, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, wr: 2'b01,
      a0: 32'h7000_0004, d0: 32'h8888_8888,
      e_wr: 1'b1, e_addr: 32'h7000_0000,
      e_wd: 32'h7777_7777, e_be: 4'hF,
      e_busy: 2'b01, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, e_ovf: 1'b1, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, e_ovf: 1'b1, e_tmo: 1'b1});
    // read+write together: read wins
    tv.push_back(vec_t'{default: '0, rd: 2'b10, wr: 2'b10,
      a1: 32'h8000_0000, d1: 32'h9999_9999,
      e_ovf: 1'b1, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, e_rd: 1'b1,
      e_addr: 32'h8000_0000, e_be: 4'h3, e_busy: 2'b10,
      e_ovf: 1'b1, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, frv: 1'b1,
      frd: 32'hCAFE_F00D, e_busy: 2'b10, e_lrv: 2'b10,
      e_lrd: 32'hCAFE_F00D, e_ovf: 1'b1, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, e_ovf: 1'b1, e_tmo: 1'b1});
    // response in the limit cycle is a real response
    tv.push_back(vec_t'{default: '0, rd: 2'b01,
      a0: 32'h9000_0000, e_ovf: 1'b1, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, e_rd: 1'b1,
      e_addr: 32'h9000_0000, e_be: 4'hF, e_busy: 2'b01,
      e_ovf: 1'b1, e_tmo: 1'b1});
    for (int k = 0; k < 3; k++)
      tv.push_back(vec_t'{default: '0, e_busy: 2'b01,
        e_ovf: 1'b1, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, frv: 1'b1,
      frd: 32'h0BAD_C0DE, e_busy: 2'b01, e_lrv: 2'b01,
      e_lrd: 32'h0BAD_C0DE, e_ovf: 1'b1, e_tmo: 1'b1});
    tv.push_back(vec_t'{default: '0, e_ovf: 1'b1, e_tmo: 1'b1});
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    idle = vec_t'{default: '0};
    reset_n = 1'b0;
    drive(idle);
    build();
    @(negedge clk);
    #1;
    chk("rst_rd", 0, 32'(fol.read_req), 32'd0);
    chk("rst_wr", 0, 32'(fol.write_req), 32'd0);
    chk("rst_addr", 0, fol.addr, 32'd0);
    chk("rst_be", 0, 32'(fol.byte_enable), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_flags", 0, 32'({ovf, tmo}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      #1;
      check_vec(i, tv[i]);
      @(negedge clk);
    end

    // reset in the middle of an outstanding read
    v = idle;
    v.rd = 2'b10;
    v.a1 = 32'hA000_0000;
    drive(v);
    @(negedge clk);
    drive(idle);
    #1;
    chk("mr_issue", 0, 32'(fol.read_req), 32'd1);
    chk("mr_busy", 0, 32'(busy), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("mr_rd", 0, 32'(fol.read_req), 32'd0);
    chk("mr_addr", 0, fol.addr, 32'd0);
    chk("mr_wd", 0, fol.write_data, 32'd0);
    chk("mr_busy0", 0, 32'(busy), 32'd0);
    chk("mr_flags", 0, 32'({ovf, tmo}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    v = idle;
    v.frv = 1'b1;
    v.frd = 32'h5151_5151;
    drive(v);
    #1;
    chk("mr_stray", 0,
        32'({ldr[1].read_data_valid, ldr[0].read_data_valid}),
        32'd0);
    @(negedge clk);
    v = idle;
    v.wr = 2'b01;
    v.a0 = 32'hB000_0000;
    v.d0 = 32'h0000_00B0;
    drive(v);
    @(negedge clk);
    drive(idle);
    #1;
    chk("mr_wr", 0, 32'(fol.write_req), 32'd1);
    chk("mr_wa", 0, fol.addr, 32'hB000_0000);
    chk("mr_wbusy", 0, 32'(busy), 32'd1);
    chk("mr_flags2", 0, 32'({ovf, tmo}), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
